// File: rtl/nic8_pkg.sv
// nic8 shared definitions.
// Holds the fetch-phase state encoding, the default reset PC, and the opcode
// field positions that the fetch sequencer and the decoder both use.
package nic8_pkg;

    localparam int INSTR_W = 8;

    // Default PC loaded on reset.
    localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

    // Opcode layout: {bit7, dest[6:4], bit3, source[2:0]}
    localparam int OP_BIT7     = 7;
    localparam int OP_DEST_MSB = 6;
    localparam int OP_DEST_LSB = 4;
    localparam int OP_BIT3     = 3;
    localparam int OP_SRC_MSB  = 2;
    localparam int OP_SRC_LSB  = 0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetchState_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer signal bundle.
// master: the fetch sequencer (drives rom_addr, ir, exec, pc, halted, instr_count)
// slave : ROM/decoder side (drives rom_data, bus_in, do_jump_bar, deny_fetch)
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 16
);
    logic [7:0]         rom_data;
    logic [7:0]         bus_in;
    logic               do_jump_bar;
    logic               deny_fetch;
    logic [ADDR_W-1:0]  rom_addr;
    logic [7:0]         ir;
    logic               exec;
    logic [ADDR_W-1:0]  pc;
    logic               halted;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  rom_data, bus_in, do_jump_bar, deny_fetch,
        output rom_addr, ir, exec, pc, halted, instr_count
    );

    modport slave (
        output rom_data, bus_in, do_jump_bar, deny_fetch,
        input  rom_addr, ir, exec, pc, halted, instr_count
    );
endinterface

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter register.
// Ports: clk, reset (sync, active-high), load + loadValue, inc, value.
// load takes priority over inc; increment wraps modulo 2^ADDR_W.
module program_counter #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] loadValue,
    input  logic              inc,
    output logic [ADDR_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= RESET_VAL;
        end else if (load) begin
            value <= loadValue;
        end else if (inc) begin
            value <= value + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// nic8 fetch sequencer: owns PC, instruction register and FETCH/EXEC phasing,
// detects the jump-to-self halt idiom and counts retired instructions.
// Ports: clk, reset (sync, active-high), fs (fetch_sequencer_if.master):
//   in : rom_data, bus_in, do_jump_bar, deny_fetch
//   out: rom_addr (= pc), ir, exec, pc, halted, instr_count
//
// state | meaning
// FETCH | latch ROM byte into ir, remember its address, advance pc
// EXEC  | decoder outputs valid; pick next pc (jump / skip operand / hold)
// HALT  | jump-to-self seen; everything frozen until reset
module fetch_sequencer
    import nic8_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                COUNT_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master fs
);

    fetchState_t          state, stateNext;
    logic [ADDR_W-1:0]    pcValue;
    logic [ADDR_W-1:0]    irAddr;
    logic [ADDR_W-1:0]    busAddr;
    logic [INSTR_W-1:0]   irReg;
    logic [COUNT_W-1:0]   instrCount;
    logic                 haltedReg;
    logic                 pcLoad, pcInc, irLoad, haltSet, countEn;

    // bus_in is zero-extended or truncated to the address width.
    assign busAddr = ADDR_W'(fs.bus_in);

    program_counter #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load      (pcLoad),
        .loadValue (busAddr),
        .inc       (pcInc),
        .value     (pcValue)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcLoad    = 1'b0;
        pcInc     = 1'b0;
        irLoad    = 1'b0;
        haltSet   = 1'b0;
        countEn   = 1'b0;
        case (state)
            FETCH: begin
                irLoad    = 1'b1;
                pcInc     = 1'b1;
                stateNext = EXEC;
            end
            EXEC: begin
                countEn = 1'b1;
                if (!fs.do_jump_bar) begin
                    pcLoad = 1'b1;
                    // Jumping to the instruction's own address is the halt idiom.
                    if (busAddr == irAddr) begin
                        haltSet   = 1'b1;
                        stateNext = HALT;
                    end else begin
                        stateNext = FETCH;
                    end
                end else begin
                    // Immediate operand sits at pc; skip it without an extra cycle.
                    pcInc     = fs.deny_fetch;
                    stateNext = FETCH;
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    // ir only changes on the FETCH edge, so it is stable for the whole EXEC
    // cycle that the decoder's gated triggers sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            irReg      <= '0;
            irAddr     <= RESET_PC;
            haltedReg  <= 1'b0;
            instrCount <= '0;
        end else begin
            if (irLoad) begin
                irReg  <= fs.rom_data;
                irAddr <= pcValue;
            end
            if (haltSet) begin
                haltedReg <= 1'b1;
            end
            if (countEn && (instrCount != '1)) begin
                instrCount <= instrCount + COUNT_W'(1);
            end
        end
    end

    assign fs.rom_addr    = pcValue;
    assign fs.pc          = pcValue;
    assign fs.ir          = irReg;
    assign fs.exec        = (state == EXEC);
    assign fs.halted      = haltedReg;
    assign fs.instr_count = instrCount;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rom [256];
    int         checkCount = 0;
    int         passCount  = 0;
    int         failCount  = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(8), .COUNT_W(16)) fsIf ();
    fetch_sequencer_if #(.ADDR_W(8), .COUNT_W(4))  fsIf4 ();

    fetch_sequencer #(.ADDR_W(8), .COUNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .fs    (fsIf.master)
    );

    // Narrow-counter instance runs straight-line code for the saturation check.
    fetch_sequencer #(.ADDR_W(8), .COUNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .fs    (fsIf4.master)
    );

    assign fsIf.rom_data     = rom[fsIf.rom_addr];
    assign fsIf4.rom_data    = rom[fsIf4.rom_addr];
    assign fsIf4.bus_in      = 8'h00;
    assign fsIf4.do_jump_bar = 1'b1;
    assign fsIf4.deny_fetch  = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0]     = 8'h12;
        rom[1]     = 8'h34;
        rom[5]     = 8'hC3;
        rom[7]     = 8'hE7;
        rom[8'h40] = 8'h9A;
        rom[8'hFE] = 8'h6E;
        rom[8'hFF] = 8'h5F;
        fsIf.bus_in      = 8'h00;
        fsIf.do_jump_bar = 1'b1;
        fsIf.deny_fetch  = 1'b0;

        // Reset state
        tick();
        doReset();
        check("rst_pc",     fsIf.pc, 8'h00);
        check("rst_ir",     fsIf.ir, 8'h00);
        check("rst_exec",   fsIf.exec, 1'b0);
        check("rst_halted", fsIf.halted, 1'b0);
        check("rst_count",  fsIf.instr_count, 16'h0000);

        // 1: straight-line fetch/exec
        tick();
        check("t1_c1_ir",   fsIf.ir, 8'h12);
        check("t1_c1_pc",   fsIf.pc, 8'h01);
        check("t1_c1_exec", fsIf.exec, 1'b1);
        tick();
        check("t1_c2_exec", fsIf.exec, 1'b0);
        check("t1_c2_cnt",  fsIf.instr_count, 16'h0001);
        tick();
        check("t1_c3_ir",   fsIf.ir, 8'h34);
        check("t1_c3_pc",   fsIf.pc, 8'h02);
        tick();
        check("t1_c4_cnt",  fsIf.instr_count, 16'h0002);
        check("t1_c4_pc",   fsIf.pc, 8'h02);

        // 2: immediate operand skipped
        rom[1] = 8'h55;
        rom[2] = 8'h77;
        doReset();
        tick();
        check("t2_ir_op", fsIf.ir, 8'h12);
        fsIf.deny_fetch = 1'b1;
        tick();
        check("t2_pc_skip", fsIf.pc, 8'h02);
        fsIf.deny_fetch = 1'b0;
        tick();
        check("t2_ir_next", fsIf.ir, 8'h77);
        check("t2_pc_next", fsIf.pc, 8'h03);

        // 3: jump from ir_addr=05 to 40
        doReset();
        tick();
        fsIf.do_jump_bar = 1'b0; fsIf.bus_in = 8'h05;
        tick();
        check("t3_pc_05", fsIf.pc, 8'h05);
        fsIf.do_jump_bar = 1'b1;
        tick();
        check("t3_ir_c3", fsIf.ir, 8'hC3);
        fsIf.do_jump_bar = 1'b0; fsIf.bus_in = 8'h40;
        tick();
        check("t3_pc_40",    fsIf.pc, 8'h40);
        check("t3_romaddr",  fsIf.rom_addr, 8'h40);
        check("t3_exec0",    fsIf.exec, 1'b0);
        check("t3_nohalt",   fsIf.halted, 1'b0);
        fsIf.do_jump_bar = 1'b1;
        tick();
        check("t3_ir_9a", fsIf.ir, 8'h9A);
        check("t3_pc_41", fsIf.pc, 8'h41);

        // 4: halt on jump-to-self at 07
        fsIf.do_jump_bar = 1'b0; fsIf.bus_in = 8'h07;
        tick();
        check("t4_pc_07", fsIf.pc, 8'h07);
        check("t4_nohalt", fsIf.halted, 1'b0);
        fsIf.do_jump_bar = 1'b1;
        tick();
        check("t4_ir_e7", fsIf.ir, 8'hE7);
        fsIf.do_jump_bar = 1'b0; fsIf.bus_in = 8'h07;
        tick();
        check("t4_halted", fsIf.halted, 1'b1);
        check("t4_pc",     fsIf.pc, 8'h07);
        check("t4_cnt",    fsIf.instr_count, 16'h0004);
        for (int i = 0; i < 12; i++) begin
            fsIf.do_jump_bar = i[0];
            fsIf.deny_fetch  = ~i[0];
            fsIf.bus_in      = 8'(i * 17);
            tick();
            check("t4_hold_pc",   fsIf.pc, 8'h07);
            check("t4_hold_exec", fsIf.exec, 1'b0);
        end
        check("t4_hold_cnt", fsIf.instr_count, 16'h0004);
        check("t4_hold_ir",  fsIf.ir, 8'hE7);
        check("t4_hold_hlt", fsIf.halted, 1'b1);
        fsIf.do_jump_bar = 1'b1; fsIf.deny_fetch = 1'b0; fsIf.bus_in = 8'h00;

        // 6: reset while halted
        doReset();
        check("t6h_pc",  fsIf.pc, 8'h00);
        check("t6h_ir",  fsIf.ir, 8'h00);
        check("t6h_hlt", fsIf.halted, 1'b0);
        check("t6h_cnt", fsIf.instr_count, 16'h0000);

        // 6: reset mid-EXEC
        tick();
        check("t6e_exec", fsIf.exec, 1'b1);
        doReset();
        check("t6e_pc",   fsIf.pc, 8'h00);
        check("t6e_ir",   fsIf.ir, 8'h00);
        check("t6e_exec0", fsIf.exec, 1'b0);
        check("t6e_cnt",  fsIf.instr_count, 16'h0000);
        tick();
        check("t6e_fetch_ir", fsIf.ir, 8'h12);
        check("t6e_fetch_pc", fsIf.pc, 8'h01);

        // 5: pc wrap on fetch and on operand skip
        doReset();
        tick();
        fsIf.do_jump_bar = 1'b0; fsIf.bus_in = 8'hFF;
        tick();
        check("t5_pc_ff", fsIf.pc, 8'hFF);
        fsIf.do_jump_bar = 1'b1;
        tick();
        check("t5_ir_5f",   fsIf.ir, 8'h5F);
        check("t5_wrap_00", fsIf.rom_addr, 8'h00);
        fsIf.deny_fetch = 1'b1;
        tick();
        check("t5_skip_01", fsIf.pc, 8'h01);
        fsIf.deny_fetch = 1'b0;
        tick();
        fsIf.do_jump_bar = 1'b0; fsIf.bus_in = 8'hFE;
        tick();
        fsIf.do_jump_bar = 1'b1;
        tick();
        check("t5_ir_6e", fsIf.ir, 8'h6E);
        check("t5_pc_ff2", fsIf.pc, 8'hFF);
        fsIf.deny_fetch = 1'b1;
        tick();
        check("t5_skipwrap_00", fsIf.pc, 8'h00);
        fsIf.deny_fetch = 1'b0;

        // 5: counter saturation (COUNT_W=4) vs 16-bit counter
        doReset();
        check("t5_cnt4_rst", fsIf4.instr_count, 4'h0);
        for (int i = 0; i < 28; i++) tick();
        check("t5_cnt4_14", fsIf4.instr_count, 4'hE);
        for (int i = 0; i < 12; i++) tick();
        check("t5_cnt4_sat", fsIf4.instr_count, 4'hF);
        check("t5_cnt16_20", fsIf.instr_count, 16'h0014);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
